// File: rtl/dvi_timing_pattern_gen.sv
// Parametrised video timing generator with a built-in test-pattern source.
// All outputs are registered and describe the counter position of the previous cycle.
module dvi_timing_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0,
    parameter int unsigned COLOR_BITS = 8,
    parameter int unsigned CHECK_LOG2 = 5,
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW        = $clog2(H_TOTAL),
    localparam int unsigned VW        = $clog2(V_TOTAL)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic [HW-1:0]         x,
    output logic [VW-1:0]         y,
    output logic                  frame_start,
    output logic [15:0]           frame_count
);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic [15:0]   frame_q, frame_d;
    logic [1:0]    mode_q, mode_d;

    logic                    active;
    logic                    de_d, hsync_d, vsync_d, frame_start_d;
    logic [HW-1:0]           x_d;
    logic [VW-1:0]           y_d;
    logic [2:0]              bar_idx;
    logic [3*COLOR_BITS-1:0] pix, rgb_d;

    function automatic logic [3*COLOR_BITS-1:0] bar_colour(input logic [2:0] idx);
        return {{COLOR_BITS{~idx[1]}}, {COLOR_BITS{~idx[2]}}, {COLOR_BITS{~idx[0]}}};
    endfunction

    assign frame_count = frame_q;

    // Counter advance; the pattern mode is only sampled on the wrap to (0,0).
    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        frame_d = frame_q;
        mode_d  = mode_q;
        if (enable) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                if (vc_q == V_LAST) begin
                    vc_d    = '0;
                    frame_d = frame_q + 16'd1;
                    mode_d  = mode;
                end else begin
                    vc_d = vc_q + VW'(1);
                end
            end else begin
                hc_d = hc_q + HW'(1);
            end
        end
    end

    // Bar index = floor(hc*8/H_ACTIVE): count the constant thresholds ceil(k*H_ACTIVE/8) passed.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (hc_q >= HW'((k * H_ACTIVE + 7) / 8)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end
    end

    always_comb begin
        pix = '0;
        case (mode_q)
            2'd0: pix = bar_colour(bar_idx);
            2'd1: pix = (hc_q[CHECK_LOG2] ^ vc_q[CHECK_LOG2]) ? '1 : '0;
            2'd2: pix = {COLOR_BITS'(hc_q), COLOR_BITS'(vc_q), COLOR_BITS'(frame_q)};
            2'd3: pix = bar_colour(frame_q[2:0]);
            default: pix = '0;
        endcase
    end

    always_comb begin
        active        = (hc_q <= H_ACT_LAST) && (vc_q <= V_ACT_LAST);
        de_d          = enable && active;
        rgb_d         = de_d ? pix : '0;
        hsync_d       = (enable && hc_q >= HS_FIRST && hc_q <= HS_LAST) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (enable && vc_q >= VS_FIRST && vc_q <= VS_LAST) ? VSYNC_POL : ~VSYNC_POL;
        frame_start_d = enable && (hc_q == '0) && (vc_q == '0);
        // Coordinates freeze while paused so they keep naming the last emitted pixel.
        x_d           = enable ? hc_q : x;
        y_d           = enable ? vc_q : y;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q               <= '0;
            vc_q               <= '0;
            frame_q            <= '0;
            mode_q             <= '0;
            de                 <= 1'b0;
            hsync              <= ~HSYNC_POL;
            vsync              <= ~VSYNC_POL;
            {red, green, blue} <= '0;
            x                  <= '0;
            y                  <= '0;
            frame_start        <= 1'b0;
        end else begin
            hc_q               <= hc_d;
            vc_q               <= vc_d;
            frame_q            <= frame_d;
            mode_q             <= mode_d;
            de                 <= de_d;
            hsync              <= hsync_d;
            vsync              <= vsync_d;
            {red, green, blue} <= rgb_d;
            x                  <= x_d;
            y                  <= y_d;
            frame_start        <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_dvi_timing_pattern_gen.sv
// Directed bench for dvi_timing_pattern_gen: 640-pixel lines with a short 38-line frame.
module tb_dvi_timing_pattern_gen;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 33;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic          hsync, vsync, de, frame_start;
    logic [7:0]    red, green, blue;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic [15:0]   frame_count;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned t_frame = 0;

    dvi_timing_pattern_gen #(
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0),
        .COLOR_BITS(8),
        .CHECK_LOG2(5)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .x          (x),
        .y          (y),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_pixel(input int tx, input int ty);
        int n = 0;
        while (!(int'(x) == tx && int'(y) == ty) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME) begin
            checks++; errors++;
            $display("FAIL wait_pixel timeout: at x=%0d y=%0d, wanted x=%0d y=%0d",
                     x, y, tx, ty);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; mode = 2'd0;
        repeat (5) @(negedge clk);
        checks++; if (de !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de); end
        checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin
            errors++; $display("FAIL reset_sync: got hs=%b vs=%b want 1 1", hsync, vsync); end
        checks++; if ({red, green, blue} !== 24'h0) begin
            errors++; $display("FAIL reset_rgb: got %h want 000000", {red, green, blue}); end
        checks++; if (frame_count !== 16'd0 || frame_start !== 1'b0) begin
            errors++; $display("FAIL reset_frame: got cnt=%0d fs=%b want 0 0", frame_count, frame_start); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (de !== 1'b1 || frame_start !== 1'b1) begin
            errors++; $display("FAIL first_pixel: got de=%b fs=%b want 1 1", de, frame_start); end
        checks++; if (x !== '0 || y !== '0 || {red, green, blue} !== 24'hffffff) begin
            errors++; $display("FAIL first_pixel_xy: got x=%0d y=%0d rgb=%h want 0 0 ffffff",
                               x, y, {red, green, blue}); end
        t_frame = cyc;
    endtask

    task automatic test_line_timing();
        int de_cnt = 0, de_fall = -1, hs_cnt = 0, hs_first = -1, hs_last = -1, xbad = 0;
        for (int i = 0; i < H_TOTAL; i++) begin
            if (i > 0) @(negedge clk);
            if (de) de_cnt++;
            else if (de_fall < 0) de_fall = i;
            if (hsync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (int'(x) != i || int'(y) != 0) xbad++;
        end
        @(negedge clk);
        checks++; if (de_cnt != 640 || de_fall != 640) begin
            errors++; $display("FAIL line_de: got cnt=%0d fall=%0d want 640 640", de_cnt, de_fall); end
        checks++; if (hs_first != 656 || hs_last != 751 || hs_cnt != 96) begin
            errors++; $display("FAIL line_hsync: got first=%0d last=%0d cnt=%0d want 656 751 96",
                               hs_first, hs_last, hs_cnt); end
        checks++; if (xbad != 0) begin errors++; $display("FAIL line_x: got %0d bad x want 0", xbad); end
        checks++; if (int'(x) != 0 || int'(y) != 1 || de !== 1'b1) begin
            errors++; $display("FAIL line_period: got x=%0d y=%0d de=%b want 0 1 1", x, y, de); end
    endtask

    task automatic test_colour_bars();
        int          xs[10]  = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639};
        logic [23:0] exp[10] = '{24'hffffff, 24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                 24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000, 24'h000000};
        for (int k = 0; k < 10; k++) begin
            wait_pixel(xs[k], 1);
            checks++; if ({red, green, blue} !== exp[k]) begin
                errors++; $display("FAIL bar_x%0d: got %h want %h", xs[k], {red, green, blue}, exp[k]); end
        end
        wait_pixel(700, 1);
        checks++; if ({red, green, blue} !== 24'h0 || de !== 1'b0) begin
            errors++; $display("FAIL bar_blank: got de=%b rgb=%h want 0 000000", de, {red, green, blue}); end
    endtask

    task automatic test_mode_change();
        wait_pixel(0, 10);
        mode = 2'd1;
        wait_pixel(0, 11);
        checks++; if ({red, green, blue} !== 24'hffffff) begin
            errors++; $display("FAIL mode_hold_x0: got %h want ffffff", {red, green, blue}); end
        wait_pixel(240, 11);
        checks++; if ({red, green, blue} !== 24'h00ff00) begin
            errors++; $display("FAIL mode_hold_x240: got %h want 00ff00", {red, green, blue}); end
    endtask

    task automatic test_frame_timing();
        int n = 0, vs_cnt = 0, vf_x = -1, vf_y = -1, vl_x = -1, vl_y = -1, blank_bad = 0;
        bit done = 1'b0;
        while (!done && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
            if (frame_start) done = 1'b1;
            else begin
                if (vsync === 1'b0) begin
                    vs_cnt++;
                    if (vf_y < 0) begin vf_x = int'(x); vf_y = int'(y); end
                    vl_x = int'(x); vl_y = int'(y);
                end
                if (!de && {red, green, blue} != 24'h0) blank_bad++;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL frame_wait: got timeout want frame_start"); end
        checks++; if (vs_cnt != 1600) begin
            errors++; $display("FAIL vsync_len: got %0d want 1600", vs_cnt); end
        checks++; if (vf_x != 0 || vf_y != 35 || vl_x != 799 || vl_y != 36) begin
            errors++; $display("FAIL vsync_pos: got (%0d,%0d)..(%0d,%0d) want (0,35)..(799,36)",
                               vf_x, vf_y, vl_x, vl_y); end
        checks++; if (blank_bad != 0) begin
            errors++; $display("FAIL blank_rgb: got %0d nonzero want 0", blank_bad); end
        checks++; if (cyc - t_frame != FRAME) begin
            errors++; $display("FAIL frame_period: got %0d want %0d", cyc - t_frame, FRAME); end
        checks++; if (frame_count !== 16'd1) begin
            errors++; $display("FAIL frame_count1: got %0d want 1", frame_count); end
        t_frame = cyc;
    endtask

    task automatic test_checker_top();
        checks++; if ({red, green, blue} !== 24'h0) begin
            errors++; $display("FAIL chk_0_0: got %h want 000000", {red, green, blue}); end
        wait_pixel(32, 0);
        checks++; if ({red, green, blue} !== 24'hffffff) begin
            errors++; $display("FAIL chk_32_0: got %h want ffffff", {red, green, blue}); end
    endtask

    task automatic test_enable_pause();
        int frozen_bad = 0, out_bad = 0;
        wait_pixel(100, 20);
        enable = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (int'(x) != 100 || int'(y) != 20) frozen_bad++;
            if (de || {red, green, blue} != 24'h0 || frame_start || !hsync || !vsync) out_bad++;
        end
        checks++; if (frozen_bad != 0) begin
            errors++; $display("FAIL pause_xy: got %0d moved samples want 0", frozen_bad); end
        checks++; if (out_bad != 0) begin
            errors++; $display("FAIL pause_outputs: got %0d active samples want 0", out_bad); end
        checks++; if (frame_count !== 16'd1) begin
            errors++; $display("FAIL pause_count: got %0d want 1", frame_count); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (int'(x) != 101 || int'(y) != 20 || de !== 1'b1 || {red, green, blue} !== 24'hffffff) begin
            errors++; $display("FAIL resume: got x=%0d y=%0d de=%b rgb=%h want 101 20 1 ffffff",
                               x, y, de, {red, green, blue}); end
    endtask

    task automatic test_checker_bottom();
        wait_pixel(0, 32);
        checks++; if ({red, green, blue} !== 24'hffffff) begin
            errors++; $display("FAIL chk_0_32: got %h want ffffff", {red, green, blue}); end
        wait_pixel(32, 32);
        checks++; if ({red, green, blue} !== 24'h0) begin
            errors++; $display("FAIL chk_32_32: got %h want 000000", {red, green, blue}); end
        mode = 2'd2;
    endtask

    task automatic test_frame_extended();
        int n = 0;
        while (!frame_start && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++; if (cyc - t_frame != FRAME + 50) begin
            errors++; $display("FAIL ext_period: got %0d want %0d", cyc - t_frame, FRAME + 50); end
        checks++; if (frame_count !== 16'd2) begin
            errors++; $display("FAIL frame_count2: got %0d want 2", frame_count); end
    endtask

    task automatic test_gradient();
        checks++; if ({red, green, blue} !== 24'h000002) begin
            errors++; $display("FAIL grad_0_0: got %h want 000002", {red, green, blue}); end
        wait_pixel(200, 5);
        checks++; if ({red, green, blue} !== 24'hc80502) begin
            errors++; $display("FAIL grad_200_5: got %h want c80502", {red, green, blue}); end
        wait_pixel(300, 7);
        checks++; if ({red, green, blue} !== 24'h2c0702) begin
            errors++; $display("FAIL grad_300_7: got %h want 2c0702", {red, green, blue}); end
        wait_pixel(700, 7);
    endtask

    task automatic test_reset_mid_frame();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (de !== 1'b0 || hsync !== 1'b1 || x !== '0 || y !== '0 || frame_count !== 16'd0) begin
            errors++; $display("FAIL mid_reset: got de=%b hs=%b x=%0d y=%0d cnt=%0d want 0 1 0 0 0",
                               de, hsync, x, y, frame_count); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (frame_start !== 1'b1 || de !== 1'b1 || frame_count !== 16'd0) begin
            errors++; $display("FAIL restart: got fs=%b de=%b cnt=%0d want 1 1 0",
                               frame_start, de, frame_count); end
        checks++; if ({red, green, blue} !== 24'hffffff) begin
            errors++; $display("FAIL restart_mode: got %h want ffffff", {red, green, blue}); end
        @(negedge clk);
        checks++; if (int'(x) != 1 || int'(y) != 0) begin
            errors++; $display("FAIL restart_x: got x=%0d y=%0d want 1 0", x, y); end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_colour_bars();
        test_mode_change();
        test_frame_timing();
        test_checker_top();
        test_enable_pause();
        test_checker_bottom();
        test_frame_extended();
        test_gradient();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
